// File: rtl/prog_fetch_ctrl.sv
// Instruction-fetch sequencer for the program memory region, with branch redirect and latched fetch faults.
// Optional fetch/stall performance counters are enabled with the FETCH_PERF_EN macro.
module prog_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0410,
  parameter int unsigned MEM_LAT  = 1,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iStart,
  output logic [31:0] oAddrProg,
  input  logic        iCS_P,
  output logic        oMemRd,
  input  logic [31:0] iMemData,
  output logic [31:0] oInst,
  output logic [31:0] oPC,
  output logic        oInstValid,
  input  logic        iInstReady,
  input  logic        iBranch,
  input  logic [31:0] iBranchTarget,
  output logic        oFault,
  output logic [1:0]  oFaultCode,
  output logic [31:0] oFaultAddr,
  input  logic        iClearFault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] oFetchCount,
  output logic [31:0] oStallCount
`endif
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
  localparam logic [31:0] STEP = 32'(PC_STEP);
  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_RANGE = 2'b01;
  localparam logic [1:0] CODE_ALIGN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      pc;
  logic [31:0]      pc_nxt;
  logic [CNT_W-1:0] cnt;
  logic             misaligned;

  assign oAddrProg  = pc;
  assign misaligned = (pc[1:0] != 2'b00);

  // Next state and next PC; a branch always takes priority over the normal flow.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_IDLE: begin
        if (iBranch) pc_nxt = iBranchTarget;
        if (iStart)  state_nxt = S_REQ;
      end
      S_REQ: begin
        if (iBranch) begin
          pc_nxt    = iBranchTarget;
          state_nxt = S_REQ;
        end else if (misaligned || !iCS_P) begin
          state_nxt = S_FAULT;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iBranch) begin
          pc_nxt    = iBranchTarget;
          state_nxt = S_REQ;
        end else if (cnt == '0) begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (iBranch) begin
          pc_nxt    = iBranchTarget;
          state_nxt = S_REQ;
        end else if (iInstReady) begin
          pc_nxt    = pc + STEP;
          state_nxt = S_REQ;
        end
      end
      S_FAULT: begin
        if (iClearFault) begin
          pc_nxt    = RESET_PC;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pc_nxt    = RESET_PC;
      end
    endcase
  end

  // State, PC and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      pc         <= RESET_PC;
      cnt        <= '0;
      oMemRd     <= 1'b0;
      oInst      <= '0;
      oPC        <= '0;
      oInstValid <= 1'b0;
      oFault     <= 1'b0;
      oFaultCode <= CODE_NONE;
      oFaultAddr <= '0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      oMemRd <= (state_nxt == S_REQ) && (pc_nxt[1:0] == 2'b00);
      case (state)
        S_REQ: begin
          if (!iBranch) begin
            if (misaligned) begin
              oFault     <= 1'b1;
              oFaultCode <= CODE_ALIGN;
              oFaultAddr <= pc;
            end else if (!iCS_P) begin
              oFault     <= 1'b1;
              oFaultCode <= CODE_RANGE;
              oFaultAddr <= pc;
            end else begin
              cnt <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!iBranch) begin
            if (cnt == '0) begin
              oInst      <= iMemData;
              oPC        <= pc;
              oInstValid <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        S_HOLD: begin
          if (iBranch || iInstReady) oInstValid <= 1'b0;
        end
        S_FAULT: begin
          if (iClearFault) begin
            oFault     <= 1'b0;
            oFaultCode <= CODE_NONE;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating handshake and stall counters, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      oFetchCount <= '0;
      oStallCount <= '0;
    end else if (state == S_HOLD) begin
      if (iInstReady && (oFetchCount != 32'hFFFF_FFFF)) oFetchCount <= oFetchCount + 32'd1;
      if (!iInstReady && (oStallCount != 32'hFFFF_FFFF)) oStallCount <= oStallCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prog_fetch_ctrl.sv
// Directed bench for prog_fetch_ctrl: two instances (MEM_LAT=1 and MEM_LAT=3) share control inputs,
// each with its own address-decoded memory; a PC scoreboard checks every consumed instruction.
module tb_prog_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        iStart = 1'b0;
  logic        iInstReady = 1'b0;
  logic        iBranch = 1'b0;
  logic [31:0] iBranchTarget = '0;
  logic        iClearFault = 1'b0;

  logic [31:0] addr1, addr3, inst1, inst3, pc1, pc3, faddr1, faddr3;
  logic        rd1, rd3, v1, v3, f1, f3;
  logic [1:0]  code1, code3;
  logic        cs1, cs3;
  logic [31:0] mem1, mem3;
`ifdef FETCH_PERF_EN
  logic [31:0] fcnt1, scnt1, fcnt3, scnt3;
`endif

  always #5 CLK = ~CLK;

  assign cs1  = (addr1 >= 32'h0000_0410) && (addr1 <= 32'h0000_080F);
  assign cs3  = (addr3 >= 32'h0000_0410) && (addr3 <= 32'h0000_080F);
  assign mem1 = addr1 ^ 32'hA5A5_A5A5;
  assign mem3 = addr3 ^ 32'hA5A5_A5A5;

  prog_fetch_ctrl #(.MEM_LAT(1)) u1 (
    .CLK(CLK), .RST(RST), .iStart(iStart), .oAddrProg(addr1), .iCS_P(cs1), .oMemRd(rd1),
    .iMemData(mem1), .oInst(inst1), .oPC(pc1), .oInstValid(v1), .iInstReady(iInstReady),
    .iBranch(iBranch), .iBranchTarget(iBranchTarget), .oFault(f1), .oFaultCode(code1),
    .oFaultAddr(faddr1), .iClearFault(iClearFault)
`ifdef FETCH_PERF_EN
    , .oFetchCount(fcnt1), .oStallCount(scnt1)
`endif
  );

  prog_fetch_ctrl #(.MEM_LAT(3)) u3 (
    .CLK(CLK), .RST(RST), .iStart(iStart), .oAddrProg(addr3), .iCS_P(cs3), .oMemRd(rd3),
    .iMemData(mem3), .oInst(inst3), .oPC(pc3), .oInstValid(v3), .iInstReady(iInstReady),
    .iBranch(iBranch), .iBranchTarget(iBranchTarget), .oFault(f3), .oFaultCode(code3),
    .oFaultAddr(faddr3), .iClearFault(iClearFault)
`ifdef FETCH_PERF_EN
    , .oFetchCount(fcnt3), .oStallCount(scnt3)
`endif
  );

  // Instance under observation: 0 -> u1, 1 -> u3.
  logic        sel = 1'b0;
  logic [31:0] a_addr, a_inst, a_pc, a_faddr;
  logic        a_rd, a_v, a_f;
  logic [1:0]  a_code;
  assign a_addr  = sel ? addr3  : addr1;
  assign a_inst  = sel ? inst3  : inst1;
  assign a_pc    = sel ? pc3    : pc1;
  assign a_faddr = sel ? faddr3 : faddr1;
  assign a_rd    = sel ? rd3    : rd1;
  assign a_v     = sel ? v3     : v1;
  assign a_f     = sel ? f3     : f1;
  assign a_code  = sel ? code3  : code1;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!a_v && k < 40) begin tick(1); k++; end
    chk(tag, 32'(a_v), 32'd1);
  endtask

  task automatic wait_drain(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin tick(1); k++; end
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  a_addr,  32'h0000_0410);
    chk({tag, "_rd"},    32'(a_rd), 32'd0);
    chk({tag, "_inst"},  a_inst,  32'd0);
    chk({tag, "_pc"},    a_pc,    32'd0);
    chk({tag, "_valid"}, 32'(a_v), 32'd0);
    chk({tag, "_fault"}, 32'(a_f), 32'd0);
    chk({tag, "_code"},  32'(a_code), 32'd0);
    chk({tag, "_faddr"}, a_faddr, 32'd0);
  endtask

  // Scoreboard: every handshake of the observed instance must match the next expected PC.
  always @(negedge CLK) begin
    if (!RST && a_v && iInstReady) begin
      chk("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_pc", a_pc, e);
        chk("sb_inst", a_inst, e ^ 32'hA5A5_A5A5);
      end
    end
  end

  initial begin
    // Phase 1: MEM_LAT=1 streaming and stall.
    tick(2);
    RST = 1'b0;
    chk_reset("rst1");
    exp_q.push_back(32'h0000_0410);
    exp_q.push_back(32'h0000_0414);
    exp_q.push_back(32'h0000_0418);
    iInstReady = 1'b1;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    chk("req_rd", 32'(a_rd), 32'd1);
    chk("req_valid", 32'(a_v), 32'd0);
    tick(1);
    chk("wait_valid", 32'(a_v), 32'd0);
    tick(1);
    chk("lat_valid", 32'(a_v), 32'd1);
    chk("lat_pc", a_pc, 32'h0000_0410);
    wait_drain("stream_drain");
    iInstReady = 1'b0;
    wait_valid("stall_valid");
    chk("stall_pc0", a_pc, 32'h0000_041C);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("stall_pc", a_pc, 32'h0000_041C);
      chk("stall_inst", a_inst, 32'h0000_041C ^ 32'hA5A5_A5A5);
      chk("stall_valid_hold", 32'(a_v), 32'd1);
      chk("stall_no_rd", 32'(a_rd), 32'd0);
    end
`ifdef FETCH_PERF_EN
    chk("stall_count", scnt1, 32'd5);
    chk("fetch_count_pre", fcnt1, 32'd3);
`endif
    exp_q.push_back(32'h0000_041C);
    iInstReady = 1'b1;
    wait_drain("stall_drain");
    iInstReady = 1'b0;
`ifdef FETCH_PERF_EN
    chk("fetch_count", fcnt1, 32'd4);
    chk("stall_count_final", scnt1, 32'd5);
`endif

    // Phase 2: MEM_LAT=3 branches, faults, reset mid-fetch.
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    sel = 1'b1;
    chk_reset("rst3");
    iInstReady = 1'b1;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    tick(1);
    chk("br_wait_valid", 32'(a_v), 32'd0);
    exp_q.push_back(32'h0000_0500);
    iBranch = 1'b1;
    iBranchTarget = 32'h0000_0500;
    tick(1);
    iBranch = 1'b0;
    chk("br_addr", a_addr, 32'h0000_0500);
    wait_drain("br_drain");
    iInstReady = 1'b0;

    wait_valid("oor_hold");
    iBranch = 1'b1;
    iBranchTarget = 32'h0000_0810;
    tick(1);
    iBranch = 1'b0;
    chk("oor_addr", a_addr, 32'h0000_0810);
    chk("oor_req_rd", 32'(a_rd), 32'd1);
    chk("oor_valid", 32'(a_v), 32'd0);
    tick(1);
    chk("oor_fault", 32'(a_f), 32'd1);
    chk("oor_code", 32'(a_code), 32'd1);
    chk("oor_faddr", a_faddr, 32'h0000_0810);
    chk("oor_rd", 32'(a_rd), 32'd0);
    iStart = 1'b1;
    iBranch = 1'b1;
    iBranchTarget = 32'h0000_0600;
    tick(1);
    iStart = 1'b0;
    iBranch = 1'b0;
    chk("fault_ignore_f", 32'(a_f), 32'd1);
    chk("fault_ignore_addr", a_addr, 32'h0000_0810);
    iClearFault = 1'b1;
    tick(1);
    iClearFault = 1'b0;
    chk("clr_fault", 32'(a_f), 32'd0);
    chk("clr_code", 32'(a_code), 32'd0);
    chk("clr_faddr", a_faddr, 32'h0000_0810);
    chk("clr_addr", a_addr, 32'h0000_0410);

    iBranch = 1'b1;
    iBranchTarget = 32'h0000_0412;
    tick(1);
    iBranch = 1'b0;
    chk("mis_idle_addr", a_addr, 32'h0000_0412);
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    chk("mis_req_rd", 32'(a_rd), 32'd0);
    tick(1);
    chk("mis_fault", 32'(a_f), 32'd1);
    chk("mis_code", 32'(a_code), 32'd2);
    chk("mis_faddr", a_faddr, 32'h0000_0412);
    chk("mis_rd", 32'(a_rd), 32'd0);
    iClearFault = 1'b1;
    tick(1);
    iClearFault = 1'b0;

    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    tick(1);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    chk_reset("rst_mid");
    exp_q.push_back(32'h0000_0410);
    iInstReady = 1'b1;
    iStart = 1'b1;
    tick(1);
    iStart = 1'b0;
    chk("restart_addr", a_addr, 32'h0000_0410);
    chk("restart_rd", 32'(a_rd), 32'd1);
    wait_drain("restart_drain");
    iInstReady = 1'b0;
    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
